multibyte_sub8: RTL and testbench

MULTIBYTE_SUB8 -- requirements
Module: multibyte_sub8

---
 rtl/multibyte_sub8.sv | 128 ++++++++++++
 tb/tb_multibyte_sub8.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/multibyte_sub8.sv
// Byte-serial multi-byte subtractor (LSB first) with a one-entry output register.
// Define MULTIBYTE_SUB8_ZERO_FLAG_EN to build the whole-difference zero detector.
module multibyte_sub8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       c,
  input  logic       first,
  input  logic       last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] s,
  output logic       out_last,
  output logic       cout,
  output logic [3:0] out_len,
  output logic       zero
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t     state_q, state_d;
  logic       borrow_q;
  logic [3:0] cnt_q;
  logic       acc;
  logic       is_first;
  logic       b;
  logic [7:0] g, p;
  logic [8:0] cy;
  logic [7:0] s_d;
  logic       bo;
  logic [3:0] cnt_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (acc) state_d = last ? IDLE : ACTIVE;
  end

  always_comb begin
    in_ready = ~out_valid | out_ready;
    acc      = in_valid & in_ready;
    is_first = (state_q == IDLE) | first;
  end

  // x - y - b computed as x + ~y + ~b; each carry is a flat generate/propagate sum-of-products
  always_comb begin
    logic t, pp;
    b     = is_first ? c : borrow_q;
    g     = x & ~y;
    p     = x ^ ~y;
    cy    = '0;
    cy[0] = ~b;
    for (int unsigned i = 0; i < 8; i++) begin
      t  = g[i];
      pp = p[i];
      for (int unsigned j = i; j > 0; j--) begin
        t  = t | (pp & g[j-1]);
        pp = pp & p[j-1];
      end
      cy[i+1] = t | (pp & cy[0]);
    end
    s_d = p ^ cy[7:0];
    bo  = ~cy[8];
  end

  always_comb begin
    if (is_first)          cnt_d = 4'd1;
    else if (cnt_q == '1)  cnt_d = cnt_q;
    else                   cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else if (acc) begin
      borrow_q <= bo;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      s         <= '0;
      out_last  <= 1'b0;
      cout      <= 1'b0;
      out_len   <= '0;
    end else if (acc) begin
      out_valid <= 1'b1;
      s         <= s_d;
      out_last  <= last;
      cout      <= last & bo;
      out_len   <= last ? cnt_d : '0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MULTIBYTE_SUB8_ZERO_FLAG_EN
  logic zacc_q;
  logic zacc_d;

  always_comb begin
    zacc_d = (is_first | zacc_q) & (s_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zacc_q <= 1'b0;
      zero   <= 1'b0;
    end else if (acc) begin
      zacc_q <= zacc_d;
      zero   <= last & zacc_d;
    end
  end
`else
  assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_multibyte_sub8.sv
// Self-checking bench for multibyte_sub8: vector table, corner sequences, scoreboard.
module tb_multibyte_sub8;

`ifdef MULTIBYTE_SUB8_ZERO_FLAG_EN
  localparam bit ZEN = 1'b1;
`else
  localparam bit ZEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] x = '0, y = '0;
  logic       c = 1'b0, first = 1'b0, last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] s;
  logic       out_last, cout, zero;
  logic [3:0] out_len;

  int nvec = 0;
  int nfail = 0;

  logic [14:0] sb[$];

  bit         m_active = 1'b0;
  bit         m_b = 1'b0;
  int         m_cnt = 0;
  bit         m_z = 1'b0;

  typedef struct {
    logic [7:0] x, y;
    logic       c, f, l;
    logic [7:0] s;
    logic       co;
    logic [3:0] len;
    logic       z;
  } vec_t;

  vec_t tab[14];

  multibyte_sub8 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .c(c), .first(first), .last(last),
    .out_valid(out_valid), .out_ready(out_ready), .s(s),
    .out_last(out_last), .cout(cout), .out_len(out_len), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] outs();
    return {s, out_last, cout, out_len, zero};
  endfunction

  // monitor: consumption happens at the next posedge when out_valid & out_ready
  bit          hold_pend = 1'b0;
  logic [14:0] hold_val;
  initial begin
    forever begin
      @(negedge clk);
      if (hold_pend && out_valid) chk("hold", outs(), hold_val);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_beat", outs(), 15'h7fff ^ outs());
        else chk("result", outs(), sb.pop_front());
        hold_pend = 1'b0;
      end else if (out_valid) begin
        chk("in_ready_backpressure", in_ready, 1'b0);
        hold_val  = outs();
        hold_pend = 1'b1;
      end else begin
        hold_pend = 1'b0;
      end
    end
  end

  task automatic model_reset();
    m_active = 1'b0; m_b = 1'b0; m_cnt = 0; m_z = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] bx, input logic [7:0] by, input logic bc,
                           input logic bf, input logic bl, input bit use_tab,
                           input logic [14:0] texp);
    bit fe, bb, bo, zf;
    int d;
    logic [7:0] sm;
    logic [3:0] ln;
    bit done = 1'b0;
    in_valid = 1'b1; x = bx; y = by; c = bc; first = bf; last = bl;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        fe = !m_active || bf;
        bb = fe ? bc : m_b;
        d  = int'(bx) - int'(by) - int'(bb);
        sm = 8'(d & 255);
        bo = d < 0;
        m_cnt = fe ? 1 : ((m_cnt < 15) ? m_cnt + 1 : 15);
        m_z = (fe ? 1'b1 : m_z) && (sm == 8'h00);
        m_active = !bl;
        m_b = bo;
        ln = bl ? 4'(m_cnt) : 4'd0;
        zf = ZEN && bl && m_z;
        sb.push_back(use_tab ? texp : {sm, bl, bl & bo, ln, zf});
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("in_ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_outs"}, outs(), 15'd0);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    bit stop;
    tab[0]  = '{8'h05, 8'h03, 1'b0, 1'b1, 1'b1, 8'h02, 1'b0, 4'd1, 1'b0};
    tab[1]  = '{8'h00, 8'h01, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 4'd1, 1'b0};
    tab[2]  = '{8'h05, 8'h05, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 4'd1, 1'b0};
    tab[3]  = '{8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 4'd0, 1'b0};
    tab[4]  = '{8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 4'd2, 1'b0};
    tab[5]  = '{8'h34, 8'h34, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0};
    tab[6]  = '{8'h12, 8'h12, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 4'd2, ZEN};
    tab[7]  = '{8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 4'd1, 1'b0};
    tab[8]  = '{8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 4'd1, ZEN};
    tab[9]  = '{8'h10, 8'h00, 1'b0, 1'b1, 1'b0, 8'h10, 1'b0, 4'd0, 1'b0};
    tab[10] = '{8'h20, 8'h00, 1'b1, 1'b1, 1'b0, 8'h1F, 1'b0, 4'd0, 1'b0};
    tab[11] = '{8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 4'd2, 1'b0};
    tab[12] = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 4'd1, ZEN};
    tab[13] = '{8'hA5, 8'h5A, 1'b1, 1'b1, 1'b1, 8'h4A, 1'b0, 4'd1, 1'b0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_outputs("reset");
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++)
      send_beat(tab[i].x, tab[i].y, tab[i].c, tab[i].f, tab[i].l, 1'b1,
                {tab[i].s, tab[i].l, tab[i].co, tab[i].len, tab[i].z});

    // 17-byte operation: counter saturates, arithmetic keeps going
    for (int i = 0; i < 17; i++)
      send_beat(8'($urandom), 8'($urandom), 1'($urandom), i == 0, i == 16, 1'b0, '0);

    // backpressure: 3 stalled cycles mid-stream
    fork
      for (int i = 0; i < 8; i++)
        send_beat(8'($urandom), 8'($urandom), 1'($urandom), i == 0, i == 7, 1'b0, '0);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join

    // mid-operation reset; next beat without first must still take c
    repeat (3) @(posedge clk); #1;
    send_beat(8'h44, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    chk_reset_outputs("midreset");
    @(posedge clk); #1;
    send_beat(8'h10, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, {8'h0E, 1'b1, 1'b0, 4'd1, 1'b0});

    // random stream with random output stalls
    stop = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++)
          send_beat(8'($urandom), 8'($urandom), 1'($urandom),
                    $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, 1'b0, '0);
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(posedge clk); #1;
          out_ready = $urandom_range(0, 3) != 0;
        end
        out_ready = 1'b1;
      end
    join

    repeat (6) @(posedge clk);
    chk("drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
